// File: rtl/i2s_rx_fblk_reader.sv
// I2S Rx frame-block reader.
// On each accepted frame-start pulse, sweeps the sample RAM read port over
// addresses 0..2^ADDR_W-1 and streams the returned words out through a small
// output buffer. Reads are credit-limited so the buffer can never overflow.
//
// state    | meaning
// ---------+----------------------------------------------------------
// ST_IDLE  | waiting for f_start_i with enable_i high
// ST_READ  | issuing RAM reads while buffer credit is available
// ST_DRAIN | last address issued; waiting for buffer and RAM pipe to empty
`timescale 1ns/1ps
module i2s_rx_fblk_reader #(
   parameter int ADDR_W     = 10,
   parameter int DATA_W     = 16,
   parameter int FIFO_DEPTH = 4
) (
   input  logic              WBs_CLK_i,
   input  logic              WBs_RST_i,
   input  logic              enable_i,
   input  logic              f_start_i,
   input  logic              ovr_clr_i,
   output logic [ADDR_W-1:0] ram_raddr_o,
   output logic              ram_rd_en_o,
   input  logic [DATA_W-1:0] ram_rd_data_i,
   output logic [DATA_W-1:0] smp_data_o,
   output logic              smp_valid_o,
   output logic              smp_last_o,
   input  logic              smp_ready_i,
   output logic              busy_o,
   output logic              frame_done_o,
   output logic              overrun_o,
   output logic [15:0]       frame_cnt_o
);

   localparam int PTR_W = $clog2(FIFO_DEPTH);
   localparam int CNT_W = PTR_W + 1;
   localparam logic [ADDR_W-1:0] LAST_ADDR = '1;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_READ  = 2'd1,
      ST_DRAIN = 2'd2
   } state_t;

   state_t              r_state;
   logic [ADDR_W-1:0]   r_rd_addr;
   logic                r_inflight;
   logic                r_inflight_last;
   logic                r_frame_done;
   logic                r_overrun;
   logic [15:0]         r_frame_cnt;

   logic [DATA_W-1:0]   r_fifo_data [FIFO_DEPTH];
   logic [FIFO_DEPTH-1:0] r_fifo_last;
   logic [PTR_W-1:0]    r_wr_ptr;
   logic [PTR_W-1:0]    r_rd_ptr;
   logic [CNT_W-1:0]    r_count;

   logic [CNT_W:0]      w_occupancy;
   logic                w_issue;
   logic                w_valid;
   logic                w_push;
   logic                w_pop;
   logic [CNT_W-1:0]    w_count_nxt;
   logic                w_abort;
   logic                w_start_ok;
   logic                w_ovr_set;
   logic                w_drain_done;

   // Words already buffered plus the one in the RAM pipe must leave room
   // for the word about to be requested.
   assign w_occupancy  = {1'b0, r_count} + {{CNT_W{1'b0}}, r_inflight};
   assign w_issue      = (r_state == ST_READ) &&
                         (w_occupancy < (CNT_W+1)'(FIFO_DEPTH));
   assign w_valid      = (r_count != '0);
   assign w_push       = r_inflight;
   assign w_pop        = w_valid & smp_ready_i;
   assign w_count_nxt  = r_count + CNT_W'(w_push) - CNT_W'(w_pop);
   assign w_abort      = (r_state != ST_IDLE) && !enable_i;
   assign w_start_ok   = (r_state == ST_IDLE) && f_start_i && enable_i;
   assign w_ovr_set    = (r_state != ST_IDLE) && f_start_i;
   // Leave DRAIN on the edge that empties the pipe so that busy_o drops in
   // the same cycle frame_done_o pulses.
   assign w_drain_done = (r_state == ST_DRAIN) && !r_inflight &&
                         (w_count_nxt == '0);

   assign ram_raddr_o  = r_rd_addr;
   assign ram_rd_en_o  = w_issue;
   assign smp_valid_o  = w_valid;
   assign smp_data_o   = w_valid ? r_fifo_data[r_rd_ptr] : '0;
   assign smp_last_o   = w_valid & r_fifo_last[r_rd_ptr];
   assign busy_o       = (r_state != ST_IDLE);
   assign frame_done_o = r_frame_done;
   assign overrun_o    = r_overrun;
   assign frame_cnt_o  = r_frame_cnt;

   // Frame sequencing: address sweep, RAM pipe tracking, done pulse.
   always_ff @(posedge WBs_CLK_i) begin
      if (!WBs_RST_i) begin
         r_state         <= ST_IDLE;
         r_rd_addr       <= '0;
         r_inflight      <= 1'b0;
         r_inflight_last <= 1'b0;
         r_frame_done    <= 1'b0;
      end else begin
         r_frame_done    <= 1'b0;
         r_inflight      <= w_issue && !w_abort;
         r_inflight_last <= (r_rd_addr == LAST_ADDR);
         case (r_state)
            ST_IDLE: begin
               if (w_start_ok) begin
                  r_state   <= ST_READ;
                  r_rd_addr <= '0;
               end
            end
            ST_READ: begin
               if (w_abort) begin
                  r_state <= ST_IDLE;
               end else if (w_issue) begin
                  r_rd_addr <= r_rd_addr + ADDR_W'(1);
                  if (r_rd_addr == LAST_ADDR) begin
                     r_state <= ST_DRAIN;
                  end
               end
            end
            ST_DRAIN: begin
               if (w_abort) begin
                  r_state <= ST_IDLE;
               end else if (w_drain_done) begin
                  r_state      <= ST_IDLE;
                  r_frame_done <= 1'b1;
               end
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

   // Output buffer pointers and occupancy; an abort flushes everything.
   always_ff @(posedge WBs_CLK_i) begin
      if (!WBs_RST_i || w_abort) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_push) begin
            r_wr_ptr <= r_wr_ptr + PTR_W'(1);
         end
         if (w_pop) begin
            r_rd_ptr <= r_rd_ptr + PTR_W'(1);
         end
         r_count <= w_count_nxt;
      end
   end

   // Buffer storage; stale entries are harmless since the pointers gate them.
   always_ff @(posedge WBs_CLK_i) begin
      if (w_push) begin
         r_fifo_data[r_wr_ptr] <= ram_rd_data_i;
         r_fifo_last[r_wr_ptr] <= r_inflight_last;
      end
   end

   // Frame counter and sticky overrun flag (a new overrun beats a clear).
   always_ff @(posedge WBs_CLK_i) begin
      if (!WBs_RST_i) begin
         r_frame_cnt <= '0;
         r_overrun   <= 1'b0;
      end else begin
         if (w_start_ok) begin
            r_frame_cnt <= r_frame_cnt + 16'd1;
         end
         if (w_ovr_set) begin
            r_overrun <= 1'b1;
         end else if (ovr_clr_i) begin
            r_overrun <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_i2s_rx_fblk_reader.sv
// Bench for i2s_rx_fblk_reader: a queue-level reference model checked every
// cycle, plus scenario checks with literal expected values.
`timescale 1ns/1ps
module tb_i2s_rx_fblk_reader;

   localparam int AW     = 10;
   localparam int DW     = 16;
   localparam int DEPTH  = 4;
   localparam int NWORDS = 1 << AW;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          en = 1'b0;
   logic          fst = 1'b0;
   logic          clr = 1'b0;
   logic          rdy = 1'b0;
   logic [AW-1:0] raddr;
   logic          rd_en;
   logic [DW-1:0] rdata;
   logic [DW-1:0] smp_data;
   logic          smp_valid;
   logic          smp_last;
   logic          busy;
   logic          done;
   logic          ovr;
   logic [15:0]   fcnt;

   always #5 clk = ~clk;

   i2s_rx_fblk_reader #(.ADDR_W(AW), .DATA_W(DW), .FIFO_DEPTH(DEPTH)) dut (
      .WBs_CLK_i     (clk),
      .WBs_RST_i     (rst_n),
      .enable_i      (en),
      .f_start_i     (fst),
      .ovr_clr_i     (clr),
      .ram_raddr_o   (raddr),
      .ram_rd_en_o   (rd_en),
      .ram_rd_data_i (rdata),
      .smp_data_o    (smp_data),
      .smp_valid_o   (smp_valid),
      .smp_last_o    (smp_last),
      .smp_ready_i   (rdy),
      .busy_o        (busy),
      .frame_done_o  (done),
      .overrun_o     (ovr),
      .frame_cnt_o   (fcnt)
   );

   // RAM with one cycle of read latency; garbage when no read was issued.
   logic [DW-1:0] mem [NWORDS];
   always @(posedge clk) rdata <= rd_en ? mem[raddr] : DW'($urandom);

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int n_chk = 0;
   int n_err = 0;

   task automatic chk(input string name, input int act, input int exp);
      n_chk++;
      if (act != exp) begin
         n_err++;
         $display("FAIL %s at cycle %0d: got 0x%0h expected 0x%0h", name, cyc, act, exp);
      end
   endtask

   // ---------------- reference model ----------------
   typedef struct packed { logic [DW-1:0] d; logic l; } ent_t;
   ent_t m_fifo[$];
   ent_t m_infl[$];
   int   m_state = 0;   // 0 idle, 1 reading, 2 draining
   int   m_addr  = 0;
   int   m_cnt   = 0;
   bit   m_ovr   = 0;
   bit   m_done  = 0;
   bit   m_live  = 0;

   initial begin
      int   old;
      bit   iss;
      bit   pop;
      bit   e_iss;
      ent_t e;
      forever begin
         @(negedge clk);
         if (m_live) begin
            e_iss = (m_state == 1) && ((m_fifo.size() + m_infl.size()) < DEPTH);
            chk("busy", int'(busy), int'(m_state != 0));
            chk("rd_en", int'(rd_en), int'(e_iss));
            if (e_iss) chk("raddr", int'(raddr), m_addr);
            chk("valid", int'(smp_valid), int'(m_fifo.size() > 0));
            if (m_fifo.size() > 0) begin
               chk("data", int'(smp_data), int'(m_fifo[0].d));
               chk("last", int'(smp_last), int'(m_fifo[0].l));
            end
            chk("done", int'(done), int'(m_done));
            chk("overrun", int'(ovr), int'(m_ovr));
            chk("frame_cnt", int'(fcnt), m_cnt);
            chk("fifo_bound", int'(int'(dut.r_count) <= DEPTH), 1);
         end
         @(posedge clk);
         if (!rst_n) begin
            m_fifo.delete();
            m_infl.delete();
            m_state = 0; m_addr = 0; m_cnt = 0; m_ovr = 0; m_done = 0;
            m_live = 1;
         end else if (m_live) begin
            old = m_state;
            iss = (old == 1) && ((m_fifo.size() + m_infl.size()) < DEPTH);
            pop = (m_fifo.size() > 0) && rdy;
            if (fst && old != 0) m_ovr = 1;
            else if (clr) m_ovr = 0;
            m_done = 0;
            if (old != 0 && !en) begin
               m_state = 0;
               m_fifo.delete();
               m_infl.delete();
            end else begin
               if (pop) void'(m_fifo.pop_front());
               if (m_infl.size() > 0) m_fifo.push_back(m_infl.pop_front());
               if (iss) begin
                  e.d = mem[m_addr];
                  e.l = (m_addr == NWORDS - 1);
                  m_infl.push_back(e);
                  if (m_addr == NWORDS - 1) m_state = 2;
                  m_addr++;
               end
               if (old == 0 && fst && en) begin
                  m_state = 1;
                  m_addr  = 0;
                  m_cnt   = (m_cnt + 1) % 65536;
               end
               if (old == 2 && m_fifo.size() == 0 && m_infl.size() == 0) begin
                  m_state = 0;
                  m_done  = 1;
               end
            end
         end
      end
   end

   // ---------------- stimulus helpers ----------------
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_cyc(input int n);
      while (cyc < n) tick();
   endtask

   task automatic do_reset();
      tick();
      rst_n = 1'b0; fst = 1'b0; clr = 1'b0;
      tick();
      tick();
      rst_n = 1'b1;
   endtask

   task automatic start_frame(output int t0);
      tick();
      fst = 1'b1;
      t0  = cyc;
      tick();
      fst = 1'b0;
   endtask

   task automatic wait_done(input string name, input int budget);
      bit seen = 0;
      for (int i = 0; i < budget; i++) begin
         @(negedge clk);
         if (done) begin seen = 1; break; end
      end
      chk(name, int'(seen), 1);
   endtask

   task automatic run_basic(input string tag, input int exp_cnt);
      int t0, first, fdata, nval, nlast, ldata, dcyc, bdone;
      for (int i = 0; i < NWORDS; i++) mem[i] = DW'(i);
      rdy = 1'b1; en = 1'b1;
      start_frame(t0);
      first = -1; fdata = -1; nval = 0; nlast = 0; ldata = -1; dcyc = -1; bdone = 1;
      @(negedge clk);
      chk({tag, "_first_rd_en"}, int'(rd_en), 1);
      chk({tag, "_first_raddr"}, int'(raddr), 0);
      for (int i = 0; i < 1100; i++) begin
         if (smp_valid) begin
            if (first < 0) begin first = cyc; fdata = int'(smp_data); end
            nval++;
            if (smp_last) begin nlast++; ldata = int'(smp_data); end
         end
         if (done) begin dcyc = cyc; bdone = int'(busy); break; end
         @(negedge clk);
      end
      chk({tag, "_valid_latency"}, first - t0, 3);
      chk({tag, "_first_data"}, fdata, 0);
      chk({tag, "_valid_cycles"}, nval, 1024);
      chk({tag, "_last_count"}, nlast, 1);
      chk({tag, "_last_data"}, ldata, 'h3FF);
      chk({tag, "_done_latency"}, dcyc - t0, 1027);
      chk({tag, "_busy_at_done"}, bdone, 0);
      chk({tag, "_frame_cnt"}, int'(fcnt), exp_cnt);
   endtask

   // ---------------- scenarios ----------------
   initial begin
      int t0, t1, nacc, nrd, maxa, fa, ndone;
      bit seen, found;

      do_reset();
      @(negedge clk);
      chk("rst_busy", int'(busy), 0);
      chk("rst_valid", int'(smp_valid), 0);
      chk("rst_rd_en", int'(rd_en), 0);
      chk("rst_raddr", int'(raddr), 0);
      chk("rst_frame_cnt", int'(fcnt), 0);
      chk("rst_overrun", int'(ovr), 0);

      // 1: back-to-back streaming with data = address
      run_basic("basic", 1);

      // 2: random backpressure over a frame of random data
      for (int i = 0; i < NWORDS; i++) mem[i] = DW'($urandom);
      start_frame(t0);
      nacc = 0; seen = 0;
      for (int i = 0; i < 5000; i++) begin
         tick();
         rdy = 1'($urandom_range(0, 1));
         @(negedge clk);
         if (smp_valid && rdy) nacc++;
         if (done) begin seen = 1; break; end
      end
      chk("rand_accepted", nacc, 1024);
      chk("rand_done_seen", int'(seen), 1);
      chk("rand_frame_cnt", int'(fcnt), 2);
      rdy = 1'b1;

      // 3: stalled sink limits outstanding reads to the buffer depth
      do_reset();
      rdy = 1'b0;
      start_frame(t0);
      nrd = 0; maxa = -1;
      for (int i = 0; i < 100; i++) begin
         @(negedge clk);
         if (rd_en) begin
            nrd++;
            if (int'(raddr) > maxa) maxa = int'(raddr);
         end
      end
      chk("stall_reads", nrd, 4);
      chk("stall_max_addr", maxa, 3);
      tick();
      rdy = 1'b1;
      found = 0; fa = -1;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (rd_en) begin found = 1; fa = int'(raddr); break; end
      end
      chk("resume_addr", found ? fa : -1, 4);
      wait_done("stall_done", 1200);

      // 4: overrun on busy starts, set-beats-clear, clear alone
      do_reset();
      rdy = 1'b1;
      start_frame(t0);
      wait_cyc(t0 + 503);
      fst = 1'b1; tick(); fst = 1'b0;
      @(negedge clk);
      chk("ovr_mid_frame", int'(ovr), 1);
      chk("ovr_cnt_kept", int'(fcnt), 1);
      wait_cyc(t0 + 510);
      clr = 1'b1; tick(); clr = 1'b0;
      @(negedge clk);
      chk("ovr_cleared", int'(ovr), 0);
      wait_cyc(t0 + 1026);
      fst = 1'b1; tick(); fst = 1'b0;
      @(negedge clk);
      chk("ovr_drain_exit", int'(ovr), 1);
      chk("ovr_drain_cnt", int'(fcnt), 1);
      chk("ovr_drain_done", int'(done), 1);
      start_frame(t1);
      wait_cyc(t1 + 20);
      fst = 1'b1; clr = 1'b1; tick(); fst = 1'b0; clr = 1'b0;
      @(negedge clk);
      chk("ovr_set_wins", int'(ovr), 1);
      chk("ovr_new_cnt", int'(fcnt), 2);
      wait_cyc(t1 + 30);
      clr = 1'b1; tick(); clr = 1'b0;
      @(negedge clk);
      chk("ovr_clear_alone", int'(ovr), 0);
      wait_done("ovr_frame_done", 1200);

      // 5: abort mid-frame, then restart from address 0
      do_reset();
      rdy = 1'b1;
      start_frame(t0);
      wait_cyc(t0 + 303);
      en = 1'b0; tick(); en = 1'b1;
      @(negedge clk);
      chk("abort_busy", int'(busy), 0);
      chk("abort_valid", int'(smp_valid), 0);
      chk("abort_done", int'(done), 0);
      ndone = 0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (done) ndone++;
      end
      chk("abort_no_done", ndone, 0);
      start_frame(t1);
      @(negedge clk);
      chk("restart_rd_en", int'(rd_en), 1);
      chk("restart_raddr", int'(raddr), 0);
      chk("restart_cnt", int'(fcnt), 2);
      wait_done("restart_done", 1200);

      // 6: reset pulse mid-read, then a clean frame
      do_reset();
      rdy = 1'b1;
      start_frame(t0);
      wait_cyc(t0 + 50);
      rst_n = 1'b0; tick(); rst_n = 1'b1;
      @(negedge clk);
      chk("mrst_busy", int'(busy), 0);
      chk("mrst_rd_en", int'(rd_en), 0);
      chk("mrst_raddr", int'(raddr), 0);
      chk("mrst_valid", int'(smp_valid), 0);
      chk("mrst_data", int'(smp_data), 0);
      chk("mrst_last", int'(smp_last), 0);
      chk("mrst_done", int'(done), 0);
      chk("mrst_overrun", int'(ovr), 0);
      chk("mrst_cnt", int'(fcnt), 0);
      run_basic("post_rst", 1);

      tick();
      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", n_err, n_chk);
      $fatal(1, "watchdog");
   end

endmodule
